// File: rtl/fp16_div_ctrl.sv
// FP16 divide control/format stage: unpacks operands, bypasses special cases, sequences the
// external mantissa divider and packs the quotient. Define FDIV_FLAGS_EN to build exception flags.
module fp16_div_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [15:0] result_o,
    output logic [3:0]  flags_o,
    output logic        div_st_o,
    output logic [9:0]  div_f1_o,
    output logic [9:0]  div_f2_o,
    input  logic        div_done_i,
    input  logic [10:0] div_f_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_RELEASE, S_PACK, S_OUT
    } state_t;

    state_t      state_q;
    logic        busy_q, valid_q, div_st_q, sign_q;
    logic [15:0] result_q;
    logic [9:0]  div_f1_q, div_f2_q;
    logic [4:0]  ea_q, eb_q;
    logic [10:0] quot_q;

    logic [4:0]  ea_d, eb_d;
    logic [9:0]  fa_d, fb_d;
    logic        sign_d;
    logic        nan_a_d, nan_b_d, inf_a_d, inf_b_d, zero_a_d, zero_b_d;
    logic        invalid_d, special_d;
    logic [15:0] spec_res_d;

    assign ea_d     = a_i[14:10];
    assign eb_d     = b_i[14:10];
    assign fa_d     = a_i[9:0];
    assign fb_d     = b_i[9:0];
    assign sign_d   = a_i[15] ^ b_i[15];
    assign nan_a_d  = (ea_d == 5'd31) && (fa_d != 10'd0);
    assign nan_b_d  = (eb_d == 5'd31) && (fb_d != 10'd0);
    assign inf_a_d  = (ea_d == 5'd31) && (fa_d == 10'd0);
    assign inf_b_d  = (eb_d == 5'd31) && (fb_d == 10'd0);
    // Subnormals are flushed: any zero exponent counts as zero.
    assign zero_a_d = (ea_d == 5'd0);
    assign zero_b_d = (eb_d == 5'd0);
    assign invalid_d = nan_a_d || nan_b_d || (zero_a_d && zero_b_d) || (inf_a_d && inf_b_d);

    always_comb begin
        special_d  = 1'b1;
        spec_res_d = 16'h7E00;
        if (invalid_d) begin
            spec_res_d = 16'h7E00;
        end else if (inf_a_d || zero_b_d) begin
            spec_res_d = {sign_d, 15'h7C00};
        end else if (zero_a_d || inf_b_d) begin
            spec_res_d = {sign_d, 15'h0000};
        end else begin
            special_d = 1'b0;
        end
    end

    logic signed [6:0] e_raw_d, e_d;
    logic [9:0]        mant_d;
    logic              ovf_d, unf_d;
    logic [15:0]       pack_res_d;

    assign e_raw_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 7'sd15;
    // Quotient below 1.0 needs one left shift of the mantissa and a matching exponent decrement.
    assign e_d     = quot_q[10] ? e_raw_d : e_raw_d - 7'sd1;
    assign mant_d  = quot_q[10] ? quot_q[9:0] : {quot_q[8:0], 1'b0};
    assign ovf_d   = (e_d >= 7'sd31);
    assign unf_d   = (e_d <= 7'sd0);
    assign pack_res_d = ovf_d ? {sign_q, 15'h7C00} :
                        unf_d ? {sign_q, 15'h0000} :
                                {sign_q, e_d[4:0], mant_d};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            div_st_q <= 1'b0;
            result_q <= 16'h0000;
            div_f1_q <= 10'd0;
            div_f2_q <= 10'd0;
            sign_q   <= 1'b0;
            ea_q     <= 5'd0;
            eb_q     <= 5'd0;
            quot_q   <= 11'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i) begin
                        sign_q <= sign_d;
                        ea_q   <= ea_d;
                        eb_q   <= eb_d;
                        busy_q <= 1'b1;
                        if (special_d) begin
                            result_q <= spec_res_d;
                            valid_q  <= 1'b1;
                            state_q  <= S_OUT;
                        end else begin
                            div_f1_q <= fa_d;
                            div_f2_q <= fb_d;
                            div_st_q <= 1'b1;
                            state_q  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    div_st_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done_i) begin
                        div_st_q <= 1'b1;
                        state_q  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    div_st_q <= 1'b0;
                    quot_q   <= div_f_i;
                    state_q  <= S_PACK;
                end
                S_PACK: begin
                    result_q <= pack_res_d;
                    valid_q  <= 1'b1;
                    state_q  <= S_OUT;
                end
                S_OUT: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FDIV_FLAGS_EN
    logic [3:0] flags_q;
    logic       dbz_d;

    assign dbz_d = !invalid_d && !inf_a_d && zero_b_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 4'b0000;
        end else if (state_q == S_IDLE && start_i && special_d) begin
            flags_q <= {invalid_d, dbz_d, 2'b00};
        end else if (state_q == S_PACK) begin
            flags_q <= {2'b00, ovf_d, unf_d};
        end
    end

    assign flags_o = flags_q;
`else
    assign flags_o = 4'b0000;
`endif

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign div_st_o = div_st_q;
    assign div_f1_o = div_f1_q;
    assign div_f2_o = div_f2_q;

endmodule

// File: tb/tb_fp16_div_ctrl.sv
// Directed self-checking bench for fp16_div_ctrl with a behavioural mantissa divider responder.
module tb_fp16_div_ctrl;

`ifdef FDIV_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic        clk, rst_n, start;
    logic [15:0] a, b;
    logic        busy, valid, div_st, div_done;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [9:0]  div_f1, div_f2;
    logic [10:0] div_f;

    int checks = 0;
    int errors = 0;

    fp16_div_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy), .valid_o(valid), .result_o(result), .flags_o(flags),
        .div_st_o(div_st), .div_f1_o(div_f1), .div_f2_o(div_f2),
        .div_done_i(div_done), .div_f_i(div_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider responder: sampled on the falling edge, so all of its outputs are driven away from posedge.
    int          lat = 24;
    int          cnt;
    int          st_pulses = 0;
    int          st_double = 0;
    logic        prev_st, mdl_busy;
    logic [20:0] quot;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done = 1'b0;
            div_f    = 11'd0;
            mdl_busy = 1'b0;
            prev_st  = 1'b0;
            cnt      = 0;
        end else begin
            if (div_st) begin
                st_pulses = st_pulses + 1;
                if (prev_st) st_double = st_double + 1;
            end
            prev_st = div_st;
            if (div_done) begin
                if (div_st) begin
                    div_done = 1'b0;
                    mdl_busy = 1'b0;
                end
            end else if (mdl_busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    div_done = 1'b1;
                    div_f    = quot[10:0];
                end
            end else if (div_st) begin
                mdl_busy = 1'b1;
                cnt      = lat;
                quot     = {1'b1, div_f1, 10'b0} / {10'b0, 1'b1, div_f2};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for valid after the sampling edge has already passed; cyc=1 means valid right after it.
    task automatic wait_valid(output logic [15:0] res, output logic [3:0] fl, output int cyc);
        bit got = 0;
        cyc = 1;
        res = 16'hxxxx;
        fl  = 4'hx;
        while (!got && cyc < 60) begin
            if (valid) begin
                got = 1;
                res = result;
                fl  = flags;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic do_case(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input int latv, input logic [15:0] exp_res, input logic [3:0] exp_fl,
                           input bit special);
        logic [15:0] res;
        logic [3:0]  fl;
        int          cyc, p0;
        @(negedge clk);
        a = av; b = bv; lat = latv; start = 1'b1;
        p0 = st_pulses;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(res, fl, cyc);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_flags"}, fl, FLAGS_ON ? exp_fl : 4'h0);
        if (special) begin
            check({tag, "_latency"}, cyc, 1);
            check({tag, "_st_pulses"}, st_pulses - p0, 0);
        end else begin
            check({tag, "_latency_le40"}, (cyc <= 40), 1);
            check({tag, "_st_pulses"}, st_pulses - p0, 2);
        end
        @(posedge clk); #1;
        check({tag, "_valid_one_cycle"}, valid, 1'b0);
        check({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin
        logic [15:0] res;
        logic [3:0]  fl;
        int          cyc, p0, extra;

        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_flags", flags, 4'h0);
        check("rst_div_st", div_st, 1'b0);
        check("rst_div_f1", div_f1, 10'h0);
        @(negedge clk) rst_n = 1'b1;

        do_case("one_div_one", 16'h3C00, 16'h3C00, 24, 16'h3C00, 4'b0000, 0);
        do_case("three_halves", 16'h4200, 16'h4000, 35, 16'h3E00, 4'b0000, 0);
        check("div_f1_latched", div_f1, 10'h200);
        check("div_f2_latched", div_f2, 10'h000);
        do_case("one_third", 16'h3C00, 16'h4200, 28, 16'h3554, 4'b0000, 0);
        do_case("neg_quot", 16'hC000, 16'h3800, 24, 16'hC400, 4'b0000, 0);
        do_case("div_by_zero", 16'h3C00, 16'h0000, 24, 16'h7C00, 4'b0100, 1);
        do_case("zero_zero", 16'h0000, 16'h0000, 24, 16'h7E00, 4'b1000, 1);
        do_case("inf_inf", 16'h7C00, 16'h7C00, 24, 16'h7E00, 4'b1000, 1);
        do_case("nan_in", 16'h7E00, 16'h3C00, 24, 16'h7E00, 4'b1000, 1);
        do_case("fin_inf", 16'h3C00, 16'h7C00, 24, 16'h0000, 4'b0000, 1);
        do_case("neg_zero", 16'h8000, 16'h3C00, 24, 16'h8000, 4'b0000, 1);
        do_case("neg_inf_fin", 16'hFC00, 16'h4000, 24, 16'hFC00, 4'b0000, 1);
        do_case("overflow", 16'h7BFF, 16'h0400, 30, 16'h7C00, 4'b0010, 0);
        do_case("underflow", 16'h0400, 16'h7BFF, 26, 16'h0000, 4'b0001, 0);

        // Start pulse during WAIT must be dropped.
        @(negedge clk);
        a = 16'h4200; b = 16'h4000; lat = 30; start = 1'b1;
        p0 = st_pulses;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 16'h3C00; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        wait_valid(res, fl, cyc);
        check("ign_start_result", res, 16'h3E00);
        check("ign_start_flags", fl, 4'h0);
        check("ign_start_pulses", st_pulses - p0, 2);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        check("ign_start_no_second", extra, 0);
        check("ign_start_idle", busy, 1'b0);

        // Asynchronous reset while the divider is running.
        @(negedge clk);
        a = 16'hC000; b = 16'h3800; lat = 30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_div_st", div_st, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_result", result, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        do_case("after_rst", 16'h4200, 16'h4000, 24, 16'h3E00, 4'b0000, 0);

        check("no_double_st", st_double, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_div_ctrl.md
# fp16_div_ctrl

- Control and format stage for half-precision (FP16) divide in the dnnCpu datapath.
- Accepts two packed FP16 operands and unpacks them.
- Bypasses the divider entirely for special operands.
- Otherwise it drives the downstream 11-bit mantissa divider through its st/done handshake, then normalizes, computes the exponent, packs the quotient and presents a one-cycle-valid result.

## Interface

- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (low = reset).
- start  in  1  one-cycle request; sampled only in IDLE.
- a  in  16  FP16 dividend.
- b  in  16  FP16 divisor.
- busy  out  1  high in every state except IDLE; reset 0.
- valid  out  1  one-cycle pulse when result/flags are new; reset 0.
- result  out  16  FP16 quotient; held until the next completion; reset 16'h0000.
- flags  out  4  {invalid, div_by_zero, overflow, underflow}; updated with valid; reset 4'b0.
- div_st  out  1  start/release strobe to divider; reset 0.
- div_f1  out  10  dividend mantissa (fraction of a); reset 0.
- div_f2  out  10  divisor mantissa (fraction of b); reset 0.
- div_done  in  1  divider finished, quotient valid.
- div_f  in  11  divider quotient {int bit, 10 fraction bits}, value in [0.5, 2).

## Operation

- **FSM:** IDLE, LAUNCH, WAIT, RELEASE, PACK, OUT.
- **IDLE + start:** latch sa^sb, ea, eb, fa, fb; classify.
- **Classification:**
  - Exponent 0 is treated as zero; subnormals are flushed.
  - A NaN operand, 0/0 or inf/inf -> 16'h7E00, invalid=1.
  - inf/finite -> signed inf (no flag).
  - Finite nonzero/0 -> signed inf, div_by_zero=1.
  - 0/nonzero or finite/inf -> signed zero (no flag).
  - Any special case goes directly to OUT.
  - Otherwise -> LAUNCH with div_f1=fa, div_f2=fb.
- **LAUNCH:** div_st=1 for exactly one cycle -> WAIT.
- **WAIT:** div_st=0; stay until div_done=1 -> RELEASE.
- **RELEASE:** div_st=1 for one cycle (returns divider to idle); latch div_f -> PACK.
- **PACK:**
  - e = ea - eb + 15, computed as a signed 7-bit value.
  - If div_f[10]=1: mantissa = div_f[9:0].
  - Else: mantissa = {div_f[8:0],1'b0} and e = e - 1.
  - Rounding is truncation.
  - e >= 31 -> signed inf, overflow=1.
  - e <= 0 -> signed zero, underflow=1.
  - Otherwise pack {sign, e[4:0], mantissa}.
  - -> OUT.
- **OUT:** valid=1 for one cycle; result and flags registered; -> IDLE.
- **start outside IDLE:** ignored; no queueing.
- **Reset asserted mid-operation:** FSM -> IDLE; all outputs take their reset values immediately.
  - The divider's reset is derived from the same reset at top level, so both restart together.
- **Simultaneous events:** div_done is sampled only in WAIT; stray div_done in other states is ignored.

## Timing

- **Special case:** start sampled at edge N -> valid high in cycle N+1 (latency 1).
- **Normal case:**
  - LAUNCH at N+1.
  - Divider runs 24..35 cycles, depending on restore steps.
  - RELEASE, PACK, OUT follow, one cycle each.
  - Total start-to-valid <= 40 cycles.
- **div_st:** never high two consecutive cycles; never high in WAIT.
- **Back-to-back:** earliest next start accepted is the cycle after OUT.

## Configuration

- **FDIV_FLAGS_EN defined:** flag logic is built and flags behaves as above.
- **FDIV_FLAGS_EN undefined:**
  - flags is constant 4'b0 and the flag logic is not synthesized.
  - result values and timing are identical either way.

## Test plan

- a=16'h3C00, b=16'h3C00 -> result 16'h3C00, flags 0, valid within 40 cycles, exactly one LAUNCH and one RELEASE div_st pulse.
- a=16'h4200, b=16'h4000 (3/2) -> 16'h3E00; a=16'h3C00, b=16'h4200 (1/3) -> 16'h3554 (q=0 path, truncation); a=16'hC000, b=16'h3800 -> 16'hC400.
- a=16'h3C00, b=16'h0000 -> 16'h7C00, div_by_zero=1, valid one cycle after start, div_st never asserted.
- Special-result cases:
  - a=b=16'h0000 -> 16'h7E00, invalid=1.
  - a=16'h7C00, b=16'h7C00 -> 16'h7E00, invalid=1.
  - a=16'h7E00, b=16'h3C00 -> 16'h7E00, invalid=1.
  - a=16'h3C00, b=16'h7C00 -> 16'h0000.
- Range limits: a=16'h7BFF, b=16'h0400 -> 16'h7C00, overflow=1; a=16'h0400, b=16'h7BFF -> 16'h0000, underflow=1.
- start pulsed during WAIT -> ignored, first result unchanged.
- reset low during WAIT -> busy=0, div_st=0, valid=0 immediately; a new start after release completes correctly.
- With FDIV_FLAGS_EN undefined, the divide-by-zero case yields flags=0.
